uart_tx_frame: RTL and testbench

Parametrised UART transmitter for the serial-protocol controller. It serialises DATA_BITS-wide words into asynchronous frames: start bit, data LSB first, optional even/odd parity, then 1 or 2 stop bits. Each bit is held for CLKS_PER_BIT clocks. A one-entry holding buffer lets a second word queue while a frame is on the line, so frames can go out back-to-back with no idle gap.

---
 rtl/uart_tx_frame.sv | 138 +++++++++++++
 tb/tb_uart_tx_frame.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// A one-word holding buffer allows back-to-back frames with no idle gap.
module uart_tx_frame #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = $clog2(DATA_BITS);
    localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [BaudW-1:0]     baud_q, baud_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_d, busy_d, done_d, ready_d;
    logic                 accept, frame_end, load_direct;

    assign accept      = tx_start && tx_ready;
    assign frame_end   = (state_q == StStop) && (bit_q == StopLast) && (baud_q == '0);
    // An accept at the end-of-frame edge with an empty buffer starts the next frame directly.
    assign load_direct = accept && ((state_q == StIdle) || (frame_end && !hold_full_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_out      <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_ready    <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_out      <= tx_d;
            busy        <= busy_d;
            done        <= done_d;
            tx_ready    <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (state_q != StIdle) begin
            if (baud_q != '0) begin
                baud_d = baud_q - 1'b1;
            end else begin
                baud_d = BaudMax;
                case (state_q)
                    StStart: begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                    StData: begin
                        if (bit_q == DataLast) begin
                            state_d = (PARITY_MODE != 0) ? StParity : StStop;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                    StParity: begin
                        state_d = StStop;
                        bit_d   = '0;
                    end
                    StStop: begin
                        if (bit_q == StopLast) begin
                            bit_d = '0;
                            if (hold_full_q) begin
                                state_d     = StStart;
                                shift_d     = hold_q;
                                hold_full_d = 1'b0;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (load_direct) begin
            state_d = StStart;
            shift_d = tx_data_in;
            baud_d  = BaudMax;
            bit_d   = '0;
        end else if (accept) begin
            hold_d      = tx_data_in;
            hold_full_d = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the line bit.
    always_comb begin
        done_d  = (state_d == StStop) && (bit_d == StopLast) && (baud_d == '0);
        busy_d  = (state_d != StIdle) && !(done_d && !hold_full_d);
        ready_d = !hold_full_d || done_d;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[bit_d];
            StParity: tx_d = (PARITY_MODE == 2) ? ~^shift_d : ^shift_d;
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: three configurations, directed words plus random traffic,
// checked against a frame-schedule model and a serial-line decoder.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          s;
        logic [15:0] bits;
    } frame_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : blk
        localparam int unsigned Db  = (g == 1) ? 7 : 8;
        localparam int unsigned Pm  = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
        localparam int unsigned Sb  = (g == 1) ? 2 : 1;
        localparam int unsigned Cpb = (g == 2) ? 5 : 4;
        localparam int          Nb  = 1 + Db + ((Pm != 0) ? 1 : 0) + Sb;
        localparam int          F   = Nb * Cpb;

        logic          rst;
        logic [Db-1:0] data;
        logic          start;
        logic          ready, line, busy, done;
        bit            fin = 1'b0;

        frame_t exp_q[$];
        int     st_q[$];   // edge at which each frame's start bit is launched
        int     acc_q[$];  // edge at which each frame was accepted

        uart_tx_frame #(
            .DATA_BITS   (Db),
            .CLKS_PER_BIT(Cpb),
            .PARITY_MODE (Pm),
            .STOP_BITS   (Sb)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .tx_data_in(data),
            .tx_start  (start),
            .tx_ready  (ready),
            .tx_out    (line),
            .busy      (busy),
            .done      (done)
        );

        function automatic logic [15:0] frame_bits(input int unsigned w);
            logic [15:0] v = '1;
            int ones = 0;
            v[0] = 1'b0;
            for (int i = 0; i < Db; i++) begin
                v[1+i] = w[i];
                if (w[i]) ones++;
            end
            if (Pm == 1) v[1+Db] = (ones % 2 == 1);
            if (Pm == 2) v[1+Db] = (ones % 2 == 0);
            return v;
        endfunction

        function automatic bit model_ready(input int t);
            return (st_q.size() == 0) || (st_q[$] <= t);
        endfunction

        // busy after edge t: inside a frame, or on its last cycle with a buffered successor.
        function automatic bit model_busy(input int t);
            foreach (st_q[i]) begin
                if (st_q[i] <= t && t < st_q[i] + F - 1) return 1'b1;
                if (t == st_q[i] + F - 1) begin
                    foreach (st_q[j]) begin
                        if (st_q[j] == st_q[i] + F && acc_q[j] <= t) return 1'b1;
                    end
                end
            end
            return 1'b0;
        endfunction

        task automatic step(input bit req, input int unsigned w);
            int t = cyc + 1;
            frame_t e;
            int s;
            check($sformatf("cfg%0d busy", g), int'(busy), int'(model_busy(cyc)));
            check($sformatf("cfg%0d tx_ready", g), int'(ready), int'(model_ready(t)));
            start = req;
            data  = w[Db-1:0];
            if (req && model_ready(t)) begin
                s = (st_q.size() == 0 || t >= st_q[$] + F) ? t : st_q[$] + F;
                st_q.push_back(s);
                acc_q.push_back(t);
                e.s    = s;
                e.bits = frame_bits(w);
                exp_q.push_back(e);
            end
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic quiet();
            for (int k = 0; k < 4 * F + 8; k++) begin
                if (st_q.size() == 0 || cyc > st_q[$] + F) break;
                step(1'b0, $urandom);
            end
            step(1'b0, $urandom);
        endtask

        initial begin : stim
            int unsigned words[4] = '{32'hA5, 32'h55, 32'h00, 32'hFF};
            rst   = 1'b0;
            start = 1'b0;
            data  = '0;
            #1 rst = 1'b1;
            #1;
            check($sformatf("cfg%0d reset tx_out", g), int'(line), 1);
            check($sformatf("cfg%0d reset busy", g), int'(busy), 0);
            check($sformatf("cfg%0d reset done", g), int'(done), 0);
            check($sformatf("cfg%0d reset tx_ready", g), int'(ready), 1);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);

            foreach (words[i]) begin
                step(1'b1, words[i]);
                quiet();
            end

            // Back-to-back pair with a request that must be dropped while the buffer is full.
            step(1'b1, 32'h3C);
            repeat (4) step(1'b0, $urandom);
            step(1'b1, 32'hC3);
            repeat (14) step(1'b0, $urandom);
            step(1'b1, 32'h11);
            quiet();

            // Reset in mid-frame with a queued word: nothing more may leave the line.
            step(1'b1, $urandom);
            repeat (4) step(1'b0, $urandom);
            step(1'b1, $urandom);
            repeat (11) step(1'b0, $urandom);
            #2 rst = 1'b1;
            #1;
            check($sformatf("cfg%0d abort tx_out", g), int'(line), 1);
            check($sformatf("cfg%0d abort busy", g), int'(busy), 0);
            check($sformatf("cfg%0d abort tx_ready", g), int'(ready), 1);
            st_q.delete();
            acc_q.delete();
            exp_q.delete();
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            repeat (2 * F) step(1'b0, $urandom);
            step(1'b1, 32'hA5);
            quiet();

            for (int k = 0; k < 500; k++) step($urandom_range(0, 3) == 0, $urandom);
            quiet();
            repeat (3) step(1'b0, $urandom);
            check($sformatf("cfg%0d frames outstanding", g), exp_q.size(), 0);
            fin = 1'b1;
        end

        // Line decoder: frames are located by their start bit and compared as whole bit vectors.
        initial begin : mon
            bit          act = 1'b0;
            int          cnt = 0;
            int          mstart = 0;
            logic [15:0] got = '1;
            logic        cur = 1'b1;
            frame_t      e;
            forever begin
                @(negedge clk);
                if (rst === 1'b1) begin
                    act = 1'b0;
                    check($sformatf("cfg%0d done in reset", g), int'(done), 0);
                end else begin
                    if (!act && line === 1'b0) begin
                        act    = 1'b1;
                        cnt    = 0;
                        mstart = cyc;
                        got    = '1;
                    end
                    check($sformatf("cfg%0d done", g), int'(done), int'(act && cnt == F - 1));
                    if (act) begin
                        if (cnt % Cpb == 0) begin
                            cur          = line;
                            got[cnt/Cpb] = line;
                        end else begin
                            check($sformatf("cfg%0d bit hold", g), int'(line), int'(cur));
                        end
                        cnt++;
                        if (cnt == F) begin
                            act = 1'b0;
                            check($sformatf("cfg%0d frame expected", g), int'(exp_q.size() != 0), 1);
                            if (exp_q.size() != 0) begin
                                e = exp_q.pop_front();
                                check($sformatf("cfg%0d start cycle", g), mstart, e.s);
                                check($sformatf("cfg%0d frame bits", g), int'(got), int'(e.bits));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 60000; k++) begin
            @(negedge clk);
            if (blk[0].fin && blk[1].fin && blk[2].fin) break;
        end
        check("all configs finished", int'(blk[0].fin && blk[1].fin && blk[2].fin), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
